// File: rtl/equal_pair_run_detector.sv
// Moore FSM that counts consecutive cycles where both bits of w are equal.
// x marks a run of four or more; InIdle marks that no run is in progress.
module equal_pair_run_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] w,
  output logic       x,
  output logic       InIdle
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    M1   = 5'b00010,
    M2   = 5'b00100,
    M3   = 5'b01000,
    M4   = 5'b10000
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_match;

  assign w_match = (w[1] == w[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Any non-one-hot pattern falls into default and returns to IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_match ? M1 : IDLE;
      M1:      w_state_nxt = w_match ? M2 : IDLE;
      M2:      w_state_nxt = w_match ? M3 : IDLE;
      M3:      w_state_nxt = w_match ? M4 : IDLE;
      M4:      w_state_nxt = w_match ? M4 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign InIdle = (r_state == IDLE);
  assign x      = (r_state == M4);

endmodule

// File: tb/tb_equal_pair_run_detector.sv
// Bench for equal_pair_run_detector: directed scenarios plus random w,
// compared against a saturating run-length counter.
module tb_equal_pair_run_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] w   = 2'b00;
  logic       x;
  logic       InIdle;

  int n_total = 0;
  int n_pass  = 0;
  int run_len = 0;

  equal_pair_run_detector dut (
    .clk    (clk),
    .rst    (rst),
    .w      (w),
    .x      (x),
    .InIdle (InIdle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim_time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic obs, input logic exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got=%b expected=%b at t=%0t", tag, obs, exp, $time);
  endtask

  // Apply one cycle of inputs, advance the reference run length, compare outputs.
  task automatic step(input logic r, input logic [1:0] wv, input string tag);
    rst = r;
    w   = wv;
    @(posedge clk);
    #1;
    if (r)                 run_len = 0;
    else if (wv[1] == wv[0]) run_len = (run_len < 4) ? run_len + 1 : 4;
    else                   run_len = 0;
    check_val({tag, "_inidle"}, InIdle, run_len == 0);
    check_val({tag, "_x"},      x,      run_len == 4);
    #3;
  endtask

  initial begin
    logic [1:0] pat [4];
    pat[0] = 2'b00; pat[1] = 2'b11; pat[2] = 2'b00; pat[3] = 2'b11;

    @(negedge clk);
    step(1'b1, 2'b11, "reset");
    check_val("reset_inidle_abs", InIdle, 1'b1);
    check_val("reset_x_abs",      x,      1'b0);

    // Reset released but no edge yet: still idle.
    rst = 1'b0;
    w   = 2'b11;
    #2;
    check_val("post_rst_no_edge", InIdle, 1'b1);
    #1;

    for (int i = 0; i < 4; i++) step(1'b0, pat[i], "four");
    check_val("four_x_abs", x, 1'b1);

    step(1'b0, 2'b01, "exit1");
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, "brk");
    step(1'b0, 2'b01, "brk_nm");
    check_val("brk_idle_abs", InIdle, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b11, "rerun");
    check_val("rerun_x_abs", x, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, "sat");
    check_val("sat_x_abs", x, 1'b1);
    step(1'b0, 2'b10, "sat_exit");
    check_val("sat_exit_x_abs", x, 1'b0);
    check_val("sat_exit_idle_abs", InIdle, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, "pre_mid_rst");
    step(1'b1, 2'b00, "mid_rst");
    check_val("mid_rst_idle_abs", InIdle, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, "after_rst");
    check_val("after_rst_x_abs", x, 1'b0);
    step(1'b0, 2'b00, "after_rst4");
    check_val("after_rst4_x_abs", x, 1'b1);

    // Random stream biased toward matches so M4 is reached regularly.
    for (int i = 0; i < 200; i++) begin
      logic [1:0] wr;
      logic       rr;
      wr = ($urandom_range(0, 3) != 0) ? {2{1'($urandom_range(0, 1))}}
                                       : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
      rr = ($urandom_range(0, 39) == 0);
      step(rr, wr, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/equal_pair_run_detector.md
Name: equal_pair_run_detector

Overview:
- Moore FSM that watches a 2-bit input `w` each clock.
- A cycle "matches" when the two bits of `w` are equal (`w` = 00 or 11).
- Asserts `x` once four consecutive matching cycles have been seen.
- `InIdle` flags that the FSM is in its idle/start state. Used as a standalone control block in the sequential-logic exercises set.

Parameters:
- None.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `w`  input  2  data input; match when `w[1] == w[0]`.
- `x`  output  1  high while the FSM is in the "four-or-more matches" state.
- `InIdle`  output  1  high while the FSM is in the idle state (no current run).

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `rst`.
- States, one-hot encoded: IDLE (run length 0), M1, M2, M3, M4 (run length ≥ 4).
- Register: 5 one-hot state flip-flops. Exactly one is set at any time after reset.
- On a rising `clk` edge with `rst` = 1: state ← IDLE, regardless of `w`.
- Reset outputs: `InIdle` = 1, `x` = 0.
- Transitions on rising `clk` edge with `rst` = 0; match = (`w` == 00) or (`w` == 11):
  - IDLE: match → M1; else → IDLE.
  - M1: match → M2; else → IDLE.
  - M2: match → M3; else → IDLE.
  - M3: match → M4; else → IDLE.
  - M4: match → M4 (saturates, `x` stays high); else → IDLE.
- A non-match (`w` = 01 or 10) from any state returns to IDLE, not M1. The run restarts at the next matching cycle.
- Mixed matching values count toward the same run (e.g. 00, 11, 00, 11 is a run of 4).
- Outputs are pure Moore decodes of the registered state, with no combinational path from `w`:
  - `InIdle` = 1 iff state == IDLE.
  - `x` = 1 iff state == M4.
- Latency: the fourth consecutive matching `w` sampled at edge N makes `x` = 1 immediately after edge N. A first non-match sampled at edge K makes `x` = 0 and `InIdle` = 1 after edge K.
- `rst` asserted mid-run (any state) forces IDLE at the next edge, with no partial count retained.
- Illegal one-hot states (zero or multiple bits set) recover to IDLE on the next clock edge.

Test Plan:
- Reset: `rst` = 1 for 1 edge, `w` = 11 → `InIdle` = 1, `x` = 0; `rst` = 0 → still IDLE until the first edge samples `w`.
- Four matches: `w` = 00, 11, 00, 11 on 4 successive edges → `InIdle` = 0 after edge 1; `x` = 0 after edges 1–3; `x` = 1 after edge 4.
- Break mid-run: `w` = 00, 00, 00, 01 → `x` never 1; `InIdle` = 1 after edge 4; then `w` = 11 ×4 → `x` = 1 only after the 4th of those.
- Saturation and exit: reach M4, hold `w` = 11 for 3 more edges → `x` stays 1; then `w` = 10 → `x` = 0, `InIdle` = 1 next edge.
- Reset mid-run: in M3, assert `rst` with `w` = 00 → IDLE after the edge; `x` = 0; count restarts from 0.
- Random: 200 cycles of random `w` against a reference counter (saturating at 4, cleared on non-match) → `InIdle` == (count == 0) and `x` == (count == 4) every cycle.
